// File: rtl/multi_rate_tick_gen.sv
// multi_rate_tick_gen: phase-accumulator rate ticks, sideband tick and generation-switch reset sequencing
module multi_rate_tick_gen #(
    parameter int NUM_CH = 4,
    parameter int ACC_W = 32,
    parameter int SB_DIV = 80000,
    parameter int RST_HOLD = 3,
    parameter logic [ACC_W-1:0] INC_LANE_G2 = ACC_W'(1) << (ACC_W - 3),
    parameter logic [ACC_W-1:0] INC_LANE_G3 = ACC_W'(1) << (ACC_W - 2),
    parameter logic [ACC_W-1:0] INC_LANE_G4 = ACC_W'(1) << (ACC_W - 1),
    parameter logic [ACC_W-1:0] INC_FSM_G2 = ACC_W'((64'd9697 << ACC_W) / 64'd80000),
    parameter logic [ACC_W-1:0] INC_FSM_G3 = ACC_W'((64'd19394 << ACC_W) / 64'd80000),
    parameter logic [ACC_W-1:0] INC_FSM_G4 = ACC_W'((64'd40000 << ACC_W) / 64'd80000)
) (
    input  logic                      local_clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [1:0]                gen_sel,
    input  logic                      cfg_wr,
    input  logic [$clog2(NUM_CH)-1:0] cfg_idx,
    input  logic [ACC_W-1:0]          cfg_inc,
    output logic [NUM_CH-1:0]         tick_o,
    output logic                      sb_tick,
    output logic                      rst_n_o,
    output logic                      ready
);
    localparam int IDX_W = $clog2(NUM_CH);
    localparam int SB_W = $clog2(SB_DIV);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    typedef enum logic {HOLD, RUN} state_t;
    state_t state, state_nx;
    logic [1:0] gen_q, gen_eff;
    logic gen_chg;
    logic [HOLD_W-1:0] hold_cnt, hold_nx;
    logic [SB_W-1:0] sb_cnt;
    logic [ACC_W-1:0] lane_pre, fsm_pre;
    assign gen_eff = (gen_sel == 2'd3) ? 2'd0 : gen_sel;
    assign gen_chg = (gen_sel != gen_q) && (gen_sel != 2'd3);
    assign lane_pre = (gen_eff == 2'd2) ? INC_LANE_G4 : (gen_eff == 2'd1) ? INC_LANE_G3 : INC_LANE_G2;
    assign fsm_pre = (gen_eff == 2'd2) ? INC_FSM_G4 : (gen_eff == 2'd1) ? INC_FSM_G3 : INC_FSM_G2;
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [ACC_W-1:0] inc, acc;
        logic [ACC_W:0] sum;
        logic tick, wr;
        assign sum = {1'b0, acc} + {1'b0, inc};
        assign wr = cfg_wr && (cfg_idx == IDX_W'(c));
        assign tick_o[c] = tick;
        // generation presets beat a config write; carry out of the accumulator is the tick
        always_ff @(posedge local_clk) begin
            if (rst) begin
                inc <= (c == 0) ? lane_pre : (c == 1) ? fsm_pre : '0;
                acc <= '0;
                tick <= 1'b0;
            end else if (gen_chg && c < 2) begin
                inc <= (c == 0) ? lane_pre : fsm_pre;
                acc <= '0;
                tick <= 1'b0;
            end else if (wr) begin
                inc <= cfg_inc;
                acc <= '0;
                tick <= 1'b0;
            end else if (en) begin
                acc <= sum[ACC_W-1:0];
                tick <= sum[ACC_W];
            end else begin
                tick <= 1'b0;
            end
        end
    end
    // sideband divider, pulses on the wrap edge and freezes while disabled
    always_ff @(posedge local_clk) begin
        if (rst) begin
            sb_cnt <= '0;
            sb_tick <= 1'b0;
        end else if (en) begin
            sb_tick <= (sb_cnt == SB_W'(SB_DIV - 1));
            sb_cnt <= (sb_cnt == SB_W'(SB_DIV - 1)) ? '0 : sb_cnt + 1'b1;
        end else begin
            sb_tick <= 1'b0;
        end
    end
    // next state: a generation change restarts the hold, sideband ticks count it down
    always_comb begin
        state_nx = state;
        hold_nx = hold_cnt;
        if (gen_chg) begin
            state_nx = HOLD;
            hold_nx = '0;
        end else if (state == HOLD && en && sb_tick) begin
            hold_nx = hold_cnt + 1'b1;
            state_nx = (hold_cnt == HOLD_W'(RST_HOLD - 1)) ? RUN : HOLD;
        end
    end
    // state register with registered downstream reset and ready
    always_ff @(posedge local_clk) begin
        if (rst) begin
            state <= HOLD;
            hold_cnt <= '0;
            rst_n_o <= 1'b0;
            ready <= 1'b0;
            gen_q <= gen_sel;
        end else begin
            state <= state_nx;
            hold_cnt <= hold_nx;
            rst_n_o <= (state_nx == RUN);
            ready <= (state_nx == RUN);
            gen_q <= gen_sel;
        end
    end
endmodule

// File: tb/tb_multi_rate_tick_gen.sv
// tb_multi_rate_tick_gen: scoreboard and directed checks for multi_rate_tick_gen at ACC_W=8, SB_DIV=4
module tb_multi_rate_tick_gen;
    logic local_clk = 1'b0;
    logic rst = 1'b1, en = 1'b0, cfg_wr = 1'b0;
    logic [1:0] gen_sel = 2'd0, cfg_idx = 2'd0;
    logic [7:0] cfg_inc = 8'h0;
    logic [2:0] tick_o;
    logic sb_tick, rst_n_o, ready;
    int n_run = 0, n_fail = 0;

    multi_rate_tick_gen #(.NUM_CH(3), .ACC_W(8), .SB_DIV(4), .RST_HOLD(3)) dut (
        .local_clk(local_clk), .rst(rst), .en(en), .gen_sel(gen_sel), .cfg_wr(cfg_wr),
        .cfg_idx(cfg_idx), .cfg_inc(cfg_inc), .tick_o(tick_o), .sb_tick(sb_tick),
        .rst_n_o(rst_n_o), .ready(ready)
    );

    always #5 local_clk = ~local_clk;

    typedef struct packed {logic [2:0] tick; logic sb; logic rn; logic rdy;} exp_t;
    exp_t exp_q[$];
    logic [7:0] lane [3] = '{8'h20, 8'h40, 8'h80};
    logic [7:0] fsm [3] = '{8'd31, 8'd62, 8'd128};
    logic [7:0] m_inc [3];
    logic [7:0] m_acc [3];
    logic [2:0] m_tick;
    logic [1:0] m_sbc, m_hold, m_gen;
    logic m_sb, m_run;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_run++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        exp_t e;
        logic [8:0] s;
        logic [1:0] g;
        logic chg;
        if (rst) begin
            g = (gen_sel == 2'd3) ? 2'd0 : gen_sel;
            m_inc = '{lane[g], fsm[g], 8'h0};
            m_acc = '{8'h0, 8'h0, 8'h0};
            m_tick = 3'b0; m_sbc = 2'd0; m_hold = 2'd0; m_sb = 1'b0; m_run = 1'b0; m_gen = gen_sel;
        end else begin
            chg = (gen_sel != m_gen) && (gen_sel != 2'd3);
            for (int i = 0; i < 3; i++) begin
                s = {1'b0, m_acc[i]} + {1'b0, m_inc[i]};
                if (en) begin m_acc[i] = s[7:0]; m_tick[i] = s[8]; end
                else m_tick[i] = 1'b0;
            end
            if (cfg_wr && cfg_idx < 2'd3) begin
                m_inc[cfg_idx] = cfg_inc; m_acc[cfg_idx] = 8'h0; m_tick[cfg_idx] = 1'b0;
            end
            if (chg) begin
                m_inc[0] = lane[gen_sel]; m_inc[1] = fsm[gen_sel];
                m_acc[0] = 8'h0; m_acc[1] = 8'h0; m_tick[1:0] = 2'b0;
                m_hold = 2'd0; m_run = 1'b0;
            end else if (!m_run && en && m_sb) begin
                if (m_hold == 2'd2) m_run = 1'b1;
                else m_hold = m_hold + 2'd1;
            end
            if (en) begin m_sb = (m_sbc == 2'd3); m_sbc = m_sbc + 2'd1; end
            else m_sb = 1'b0;
            m_gen = gen_sel;
        end
        e = '{m_tick, m_sb, m_run, m_run};
        exp_q.push_back(e);
        @(posedge local_clk);
        #1;
        e = exp_q.pop_front();
        chk("tick_o", 8'(tick_o), 8'(e.tick));
        chk("sb_tick", 8'(sb_tick), 8'(e.sb));
        chk("rst_n_o", 8'(rst_n_o), 8'(e.rn));
        chk("ready", 8'(ready), 8'(e.rdy));
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && !ready; i++) step();
        chk("ready_timeout", 8'(ready), 8'd1);
    endtask

    initial begin
        int cnt;
        step(); step();
        chk("reset_rst_n", 8'(rst_n_o), 8'd0);
        rst = 1'b0; en = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step();
            chk("sb_edge", 8'(sb_tick), 8'(k % 4 == 0));
            chk("ready_edge", 8'(ready), 8'(k >= 13));
        end
        cfg_wr = 1'b1; cfg_idx = 2'd0; cfg_inc = 8'h40;
        step();
        cfg_wr = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("inc40_tick", 8'(tick_o[0]), 8'(k % 4 == 0));
        end
        cfg_wr = 1'b1; cfg_idx = 2'd2; cfg_inc = 8'h60;
        step();
        cfg_wr = 1'b0;
        cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            cnt += int'(tick_o[2]);
            chk("inc60_tick", 8'(tick_o[2]), 8'(k == 3 || k == 6 || k == 8));
        end
        chk("inc60_count", 8'(cnt), 8'd3);
        en = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("frozen_tick", 8'(tick_o), 8'd0);
            chk("frozen_sb", 8'(sb_tick), 8'd0);
        end
        en = 1'b1;
        for (int k = 1; k <= 8; k++) step();
        gen_sel = 2'd2;
        step();
        chk("gen2_restart", 8'(rst_n_o), 8'd0);
        wait_ready();
        gen_sel = 2'd1;
        step();
        chk("gen1_rst_n", 8'(rst_n_o), 8'd0);
        chk("gen1_ready", 8'(ready), 8'd0);
        cnt = int'(sb_tick);
        for (int i = 0; i < 20; i++) begin
            step();
            if (ready) break;
            cnt += int'(sb_tick);
        end
        chk("gen1_rerun", 8'(ready), 8'd1);
        chk("gen1_sb_count", 8'(cnt), 8'd3);
        gen_sel = 2'd3;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("gen3_no_restart", 8'(ready), 8'd1);
        end
        gen_sel = 2'd0; cfg_wr = 1'b1; cfg_idx = 2'd0; cfg_inc = 8'h11;
        step();
        cfg_wr = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("preset_wins", 8'(tick_o[0]), 8'(k % 8 == 0));
        end
        cfg_wr = 1'b1; cfg_idx = 2'd3; cfg_inc = 8'hFF;
        step();
        cfg_wr = 1'b0;
        for (int k = 1; k <= 8; k++) step();
        wait_ready();
        rst = 1'b1; cfg_wr = 1'b1; cfg_idx = 2'd0; gen_sel = 2'd2;
        step();
        chk("rst_run_tick", 8'(tick_o), 8'd0);
        chk("rst_run_ready", 8'(ready), 8'd0);
        chk("rst_run_rst_n", 8'(rst_n_o), 8'd0);
        chk("rst_run_sb", 8'(sb_tick), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
